// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard bundle: instruction fields in, pipeline enables out.
interface hazard_scoreboard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  Freeze;
    logic                  IDValid;
    logic [REG_ADDR_W-1:0] IDRs;
    logic [REG_ADDR_W-1:0] IDRt;
    logic                  IDUsesRs;
    logic                  IDUsesRt;
    logic [REG_ADDR_W-1:0] IDDest;
    logic                  IDRegWrite;
    logic                  IDMemRead;
    logic                  IDIsBranch;
    logic                  BranchTaken;
    logic                  IDIsMulDiv;
    logic                  IDUsesHiLo;
    logic                  PCWriteEnable;
    logic                  IFIDWriteEnable;
    logic                  IDEXFlush;
    logic                  IFIDFlush;
    logic                  Branch;
    logic                  Stall;
    logic [31:0]           StallCycles;

    modport master (
        output Freeze, IDValid, IDRs, IDRt, IDUsesRs, IDUsesRt,
        output IDDest, IDRegWrite, IDMemRead, IDIsBranch,
        output BranchTaken, IDIsMulDiv, IDUsesHiLo,
        input  PCWriteEnable, IFIDWriteEnable, IDEXFlush,
        input  IFIDFlush, Branch, Stall, StallCycles
    );

    modport slave (
        input  Freeze, IDValid, IDRs, IDRt, IDUsesRs, IDUsesRt,
        input  IDDest, IDRegWrite, IDMemRead, IDIsBranch,
        input  BranchTaken, IDIsMulDiv, IDUsesHiLo,
        output PCWriteEnable, IFIDWriteEnable, IDEXFlush,
        output IFIDFlush, Branch, Stall, StallCycles
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Countdown-scoreboard hazard unit for ID-stage stalls and branch redirect.
// Define HAZ_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int REG_COUNT      = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int ALU_LATENCY    = 1,
    parameter int LOAD_LATENCY   = 2,
    parameter int MULDIV_LATENCY = 8
) (
    input logic clk_i,
    input logic rst_ni,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int CW = $clog2(LOAD_LATENCY + 1);
    localparam int HW = $clog2(MULDIV_LATENCY + 1);

    logic [CW-1:0] cnt_q [1:REG_COUNT-1];
    logic [CW-1:0] cnt_d [1:REG_COUNT-1];
    logic [HW-1:0] hilo_q;
    logic [HW-1:0] hilo_d;

    logic [CW-1:0] rs_cnt;
    logic [CW-1:0] rt_cnt;
    logic          rs_haz;
    logic          rt_haz;
    logic          hilo_haz;
    logic          stall;
    logic          issue;
    logic          branch;

    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (bus.IDRs == REG_ADDR_W'(r)) rs_cnt = cnt_q[r];
            if (bus.IDRt == REG_ADDR_W'(r)) rt_cnt = cnt_q[r];
        end
    end

    // Branches compare in ID, so they cannot use the EX forward path.
    assign rs_haz = bus.IDUsesRs & (bus.IDRs != '0) &
                    (bus.IDIsBranch ? (rs_cnt != '0) : (rs_cnt > CW'(1)));
    assign rt_haz = bus.IDUsesRt & (bus.IDRt != '0) &
                    (bus.IDIsBranch ? (rt_cnt != '0) : (rt_cnt > CW'(1)));
    assign hilo_haz = (bus.IDUsesHiLo | bus.IDIsMulDiv) & (hilo_q != '0);

    assign stall  = bus.IDValid & ~bus.Freeze & (rs_haz | rt_haz | hilo_haz);
    assign issue  = bus.IDValid & ~stall & ~bus.Freeze;
    assign branch = ~bus.Freeze & bus.IDValid & bus.IDIsBranch &
                    bus.BranchTaken & ~stall;

    assign bus.Stall           = stall;
    assign bus.PCWriteEnable   = ~bus.Freeze & ~stall;
    assign bus.IFIDWriteEnable = ~bus.Freeze & ~stall;
    assign bus.IDEXFlush       = stall;
    assign bus.Branch          = branch;
    assign bus.IFIDFlush       = branch;

    always_comb begin
        hilo_d = hilo_q;
        for (int r = 1; r < REG_COUNT; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (!bus.Freeze) begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
                if (issue && bus.IDRegWrite &&
                    bus.IDDest == REG_ADDR_W'(r)) begin
                    cnt_d[r] = bus.IDMemRead ? CW'(LOAD_LATENCY)
                                             : CW'(ALU_LATENCY);
                end
            end
            if (hilo_q != '0) hilo_d = hilo_q - 1'b1;
            if (issue && bus.IDIsMulDiv) hilo_d = HW'(MULDIV_LATENCY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 1; r < REG_COUNT; r++) begin
                cnt_q[r] <= '0;
            end
            hilo_q <= '0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            hilo_q <= hilo_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (stall && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.StallCycles = perf_q;
`else
    assign bus.StallCycles = '0;
`endif
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-cycle load-use hazard detector.
- Sits between the ID stage and the IF/ID, ID/EX pipeline registers.
- Tracks pending writes per architectural register with countdown counters instead of comparing against the EX instruction only, so it covers multi-cycle loads, ID-stage branch operand hazards and a multi-cycle HI/LO mul/div unit.
- Drives PC/IF-ID write enables, bubble insertion, branch redirect and a pipeline freeze path.

Parameters:
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.
- REG_ADDR_W, 5, register index width (must satisfy 2**REG_ADDR_W >= REG_COUNT).
- ALU_LATENCY, 1, load value for counters of ALU producers (≥1).
- LOAD_LATENCY, 2, load value for counters of load producers (≥ALU_LATENCY).
- MULDIV_LATENCY, 8, cycles the HI/LO unit stays busy after a mul/div issue (≥1).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Freeze  in  1  external whole-pipeline hold (memory wait).
- IDValid  in  1  ID stage holds a valid instruction.
- IDRs  in  REG_ADDR_W  source register rs.
- IDRt  in  REG_ADDR_W  source register rt.
- IDUsesRs  in  1  instruction reads rs.
- IDUsesRt  in  1  instruction reads rt.
- IDDest  in  REG_ADDR_W  destination register.
- IDRegWrite  in  1  instruction writes IDDest.
- IDMemRead  in  1  instruction is a load.
- IDIsBranch  in  1  branch resolved in ID; needs operands in ID.
- BranchTaken  in  1  ID comparator result.
- IDIsMulDiv  in  1  mult/div issue.
- IDUsesHiLo  in  1  mfhi/mflo/mthi/mtlo.
- PCWriteEnable  out  1  PC update enable.
- IFIDWriteEnable  out  1  IF/ID register enable.
- IDEXFlush  out  1  insert bubble into ID/EX.
- IFIDFlush  out  1  squash instruction in IF.
- Branch  out  1  take branch redirect.
- Stall  out  1  hazard stall active.
- StallCycles  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
State:
- cnt[r] for r=1..REG_COUNT-1, width clog2(LOAD_LATENCY+1).
- hilo_cnt, width clog2(MULDIV_LATENCY+1).
- All state is 0 on Reset low (asynchronous); cnt[0] does not exist and reads as 0.

Hazard terms:
- rsHaz = IDUsesRs & IDRs!=0 & (IDIsBranch ? cnt[IDRs]>0 : cnt[IDRs]>1).
- rtHaz is the same with rt.
- Non-branch consumers take the EX-forwarded value, so they stall only while cnt>1. Branch consumers need the value in ID, so they stall while cnt>0.
- hiloHaz = (IDUsesHiLo | IDIsMulDiv) & hilo_cnt!=0.
- Stall = IDValid & ~Freeze & (rsHaz | rtHaz | hiloHaz).

Outputs (combinational from state and inputs):
- Freeze=1: PCWriteEnable=0, IFIDWriteEnable=0, IDEXFlush=0, IFIDFlush=0, Branch=0.
- Freeze=0: PCWriteEnable=~Stall, IFIDWriteEnable=~Stall, IDEXFlush=Stall.
- Freeze=0: Branch = IDValid & IDIsBranch & BranchTaken & ~Stall, and IFIDFlush=Branch.
- Values during and after reset: PCWriteEnable=1, IFIDWriteEnable=1, all other outputs 0.

Issue:
- issue = IDValid & ~Stall & ~Freeze.

Counter update each rising edge:
- Freeze=1: all counters hold.
- Otherwise every nonzero counter decrements by 1 and saturates at 0.
- If issue & IDRegWrite & IDDest!=0: cnt[IDDest] loads LOAD_LATENCY when IDMemRead, else ALU_LATENCY. The load overrides that register's decrement; a load value of 0 is not possible.
- If issue & IDIsMulDiv: hilo_cnt loads MULDIV_LATENCY. A mul/div in ID while hilo_cnt!=0 stalls, so there is never a double issue.

Boundary conditions:
- A stalled instruction never loads a counter.
- Write to register 0 is ignored.
- Reset low mid-stall clears all counters immediately; Stall drops in the same cycle.
- IDValid=0 never stalls, but counters keep decrementing.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: StallCycles increments on each edge where Stall=1, saturates at 0xFFFFFFFF, and clears on reset.
- Undefined: StallCycles is tied to 0 and no counter logic exists.

Test Plan:
- Load writes r8 (LOAD_LATENCY=2), next instruction add reads r8 → exactly 1 stall cycle: PCWriteEnable=0, IFIDWriteEnable=0, IDEXFlush=1; issues on the 2nd cycle.
- ALU writes r9, next instruction is a branch on r9 with BranchTaken=1 → 1 stall cycle with Branch=0; next cycle Branch=1, IFIDFlush=1.
- Load writes r10, next instruction is a branch on r10 → 2 stall cycles, then Branch follows BranchTaken.
- Mult issue (MULDIV_LATENCY=8), mflo the next cycle → 8 stall cycles, then issue; a second mult during busy also stalls.
- Load writes r0, then a consumer of r0 → no stall. Separately: Freeze=1 for 3 cycles during a load-use stall → counters hold, all enables 0, and the stall resumes after Freeze drops.
- Reset low during a hilo stall → Stall=0 and PCWriteEnable=1 immediately. With HAZ_PERF_CNT_EN, StallCycles=0 after reset and =1 after the load-use case.
